// File: rtl/t05_bit_decoder.sv
// Huffman bit decoder: reads a 32-bit character count, then walks the stored tree one bit per level.
// Optional macro DEC_DEPTH_CHECK_EN adds a path-depth limit that raises a sticky err.
module t05_bit_decoder #(
    parameter int IDX_W     = 9,
    parameter int ROOT_IDX  = 0,
    parameter int EN_VAL    = 7,
    parameter int FIN_CODE  = 7,
    parameter int MAX_DEPTH = 127
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [3:0]             en_state,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    output logic                   bit_ready,
    output logic                   node_req,
    output logic [IDX_W-1:0]       node_addr,
    input  logic                   node_ack,
    input  logic [9+2*IDX_W-1:0]   node_data,
    output logic [7:0]             char_out,
    output logic                   char_valid,
    input  logic                   char_ready,
    output logic [31:0]            totChar,
    output logic                   err,
    output logic [2:0]             fin_state
);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_FETCH, S_BIT, S_EMIT, S_DONE} state_t;

    localparam int MSB = 9 + 2*IDX_W - 1;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   cur_q, cur_d;
    logic [IDX_W-1:0]   left_q, left_d;
    logic [IDX_W-1:0]   right_q, right_d;
    logic [5:0]         bitcnt_q, bitcnt_d;
    logic [31:0]        totchar_q, totchar_d;
    logic [31:0]        remaining_q, remaining_d;
    logic [7:0]         char_q, char_d;
    logic               enabled;

`ifdef DEC_DEPTH_CHECK_EN
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
`endif

    assign enabled = (en_state == 4'(EN_VAL));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cur_q       <= IDX_W'(ROOT_IDX);
            left_q      <= '0;
            right_q     <= '0;
            bitcnt_q    <= '0;
            totchar_q   <= '0;
            remaining_q <= '0;
            char_q      <= '0;
`ifdef DEC_DEPTH_CHECK_EN
            depth_q     <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            left_q      <= left_d;
            right_q     <= right_d;
            bitcnt_q    <= bitcnt_d;
            totchar_q   <= totchar_d;
            remaining_q <= remaining_d;
            char_q      <= char_d;
`ifdef DEC_DEPTH_CHECK_EN
            depth_q     <= depth_d;
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        left_d      = left_q;
        right_d     = right_q;
        bitcnt_d    = bitcnt_q;
        totchar_d   = totchar_q;
        remaining_d = remaining_q;
        char_d      = char_q;
        bit_ready   = 1'b0;
        node_req    = 1'b0;
        char_valid  = 1'b0;
`ifdef DEC_DEPTH_CHECK_EN
        depth_d     = depth_q;
        err_d       = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (enabled) begin
                    totchar_d = '0;
                    bitcnt_d  = '0;
                    state_d   = S_LEN;
                end
            end
            S_LEN: begin
                if (enabled) begin
                    bit_ready = 1'b1;
                    if (bit_valid) begin
                        totchar_d = {totchar_q[30:0], bit_in};
                        bitcnt_d  = bitcnt_q + 6'd1;
                        if (bitcnt_q == 6'd31) begin
                            remaining_d = totchar_d;
                            if (totchar_d == '0) begin
                                state_d = S_DONE;
                            end else begin
                                cur_d   = IDX_W'(ROOT_IDX);
`ifdef DEC_DEPTH_CHECK_EN
                                depth_d = '0;
`endif
                                state_d = S_FETCH;
                            end
                        end
                    end
                end
            end
            S_FETCH: begin
                if (enabled) begin
                    node_req = 1'b1;
                    if (node_ack) begin
                        left_d  = node_data[2*IDX_W-1:IDX_W];
                        right_d = node_data[IDX_W-1:0];
                        if (node_data[MSB]) begin
                            char_d  = node_data[MSB-1:2*IDX_W];
                            state_d = S_EMIT;
                        end else begin
                            state_d = S_BIT;
                        end
                    end
                end
            end
            S_BIT: begin
                if (enabled) begin
                    bit_ready = 1'b1;
                    if (bit_valid) begin
`ifdef DEC_DEPTH_CHECK_EN
                        // A path longer than MAX_DEPTH means a corrupt tree or stream.
                        if (depth_q == DEPTH_W'(MAX_DEPTH)) begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end else begin
                            depth_d = depth_q + DEPTH_W'(1);
                            cur_d   = bit_in ? right_q : left_q;
                            state_d = S_FETCH;
                        end
`else
                        cur_d   = bit_in ? right_q : left_q;
                        state_d = S_FETCH;
`endif
                    end
                end
            end
            S_EMIT: begin
                if (enabled) begin
                    char_valid = 1'b1;
                    if (char_ready) begin
                        remaining_d = remaining_q - 32'd1;
                        if (remaining_q == 32'd1) begin
                            state_d = S_DONE;
                        end else begin
                            cur_d   = IDX_W'(ROOT_IDX);
`ifdef DEC_DEPTH_CHECK_EN
                            depth_d = '0;
`endif
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_DONE: begin
                if (!enabled) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign node_addr = cur_q;
    assign char_out  = char_q;
    assign totChar   = totchar_q;
    assign fin_state = (state_q == S_DONE) ? 3'(FIN_CODE) : 3'd0;
`ifdef DEC_DEPTH_CHECK_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: doc/t05_bit_decoder.md
Name: t05_bit_decoder

Overview:
Huffman decompression stage, the receive-side counterpart of the encoder translation stage.
- Consumes the serial bitstream MSB-first: a 32-bit total character count, then one Huffman path per character.
- Walks the stored Huffman tree one bit at a time and emits one decoded 8-bit character per leaf reached.
- Runs only while the top-level controller's en_state equals EN_VAL. Reports completion to the controller on fin_state.

Parameters:
IDX_W, 9, width of a tree-node index (up to 512 nodes)
ROOT_IDX, 0, node index of the tree root
EN_VAL, 7, en_state value that enables this block
FIN_CODE, 7, value driven on fin_state when decoding is complete
MAX_DEPTH, 127, maximum legal path length; used only with DEC_DEPTH_CHECK_EN

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
en_state  in  4  controller state; the block advances only when en_state == EN_VAL
bit_in  in  1  next stream bit
bit_valid  in  1  bit_in is valid
bit_ready  out  1  block accepts bit_in this cycle
node_req  out  1  tree-node read request
node_addr  out  IDX_W  node index being requested
node_ack  in  1  node_data is valid for the current request
node_data  in  9+2*IDX_W  {is_leaf[MSB], char[7:0], left[IDX_W], right[IDX_W] (LSBs)}
char_out  out  8  decoded character
char_valid  out  1  char_out is valid
char_ready  in  1  consumer accepts char_out
totChar  out  32  received character count
err  out  1  depth-overflow error, sticky until reset
fin_state  out  3  FIN_CODE in DONE, otherwise 0

Behaviour:
Reset values:
- State IDLE; cur = ROOT_IDX; bitcnt = 0; totChar = 0; remaining = 0; char_out = 0; err = 0.
- All handshake outputs are 0.

Enable gating:
- When en_state != EN_VAL, all registers hold and bit_ready, node_req and char_valid are forced to 0.
- Exception: DONE returns to IDLE when en_state != EN_VAL.

State machine:
- IDLE:
  - When enabled, clear totChar and bitcnt, then go to LEN next cycle.
- LEN:
  - bit_ready = 1.
  - On each bit_valid & bit_ready: totChar <= {totChar[30:0], bit_in}; bitcnt++.
  - On the 32nd accepted bit, set remaining to the final count.
  - If the count == 0, go to DONE; otherwise set cur = ROOT_IDX and go to FETCH.
- FETCH:
  - node_req = 1; node_addr = cur. Both hold until node_ack.
  - On node_ack, latch node_data. If is_leaf, go to EMIT; otherwise go to BIT.
  - node_ack in the same cycle as node_req is legal.
- BIT:
  - bit_ready = 1.
  - On an accepted bit: cur <= bit_in ? right : left; go to FETCH.
  - Bits are never consumed outside the LEN and BIT states.
- EMIT:
  - char_valid = 1 with char_out = latched char. Both hold stable until char_ready.
  - On handshake: remaining--.
  - If remaining becomes 0, go to DONE; otherwise set cur = ROOT_IDX and go to FETCH.
- DONE:
  - fin_state = FIN_CODE.
  - Stays in DONE while enabled; goes to IDLE when en_state != EN_VAL.

Latency:
- Minimum per tree level is 2 cycles (FETCH plus BIT), assuming zero-wait node_ack and bit_valid.
- Leaf to char_valid: 1 cycle.

Boundary conditions:
- Root is a leaf (single-symbol tree): emit the char on every pass; zero bits are consumed per character.
- The 0x1A byte has no special meaning here. Termination is by count only.
- Asynchronous rst at any point returns to the reset values immediately. Any in-flight request is abandoned.

Optional Feature:
DEC_DEPTH_CHECK_EN
- Defined:
  - A depth counter is cleared at every root FETCH and incremented on each bit accepted in BIT.
  - If the depth counter would exceed MAX_DEPTH, set err = 1 and go to DONE.
  - No further chars are emitted.
- Undefined:
  - No depth counter is built; err is tied to 0.
  - A malformed, looping tree walks forever.

Test Plan:
- Tree: node0 {internal, L=1, R=2}; node1 leaf 0x41; node2 {internal, L=3, R=4}; node3 leaf 0x42; node4 leaf 0x1A.
  - Stream: 32-bit count 3, then bits 0,1,0,1,1 -> chars 0x41, 0x42, 0x1A, then fin_state = 7; totChar = 3.
- Count 0 (32 zero bits) -> no char_valid; DONE after the 32nd bit; bit_ready = 0 afterwards.
- Same tree and stream as the first scenario, with char_ready held low for 5 cycles on each char -> char_out stable; bit_ready = 0 during EMIT; identical output sequence.
- Drop en_state to 0 for 4 cycles mid-path and randomise node_ack delays (0-3 cycles) -> same output as the first scenario; no handshakes asserted while disabled.
- Assert rst during the second EMIT -> all outputs return to reset values within the same cycle; after rst release and re-enable, the first scenario's stream decodes correctly.
- With DEC_DEPTH_CHECK_EN defined: node0 {L=0, R=0}, count 1, 200 bits of 0 -> err = 1 after the 128th bit, fin_state = 7, no char emitted.
